// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, sample type, loader states and index bit-reversal for the 8-point FFT
package fft_pkg;
  localparam int FFT_N     = 4;
  localparam int FFT_PTS   = 8;
  localparam int FFT_IDX_W = 3;
  typedef logic [2**FFT_N-1:0] fft_sample_t;
  typedef enum logic {FILL, PEND} state_e;
  function automatic logic [FFT_IDX_W-1:0] bitrev3(input logic [FFT_IDX_W-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction
endpackage

// File: rtl/fft_input_loader.sv
// fft_input_loader: assembles serial samples into 8-sample frames for the FFT; FFT_LOADER_BITREV_EN selects bit-reversed output order
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N = FFT_N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**N-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_sof,
  output logic            in_ready,
  input  logic            out_hold,
  output logic [2**N-1:0] a0,
  output logic [2**N-1:0] a1,
  output logic [2**N-1:0] a2,
  output logic [2**N-1:0] a3,
  output logic [2**N-1:0] a4,
  output logic [2**N-1:0] a5,
  output logic [2**N-1:0] a6,
  output logic [2**N-1:0] a7,
  output logic            out_valid,
  output logic [7:0]      frame_cnt,
  output logic            sof_err
);
  localparam int W = 2**N;
  state_e                 state_q, state_d;
  logic [FFT_IDX_W-1:0]   wr_idx_q, wr_idx_d, idx;
  logic [W-1:0]           bank_q [FFT_PTS];
  logic [W-1:0]           bank_d [FFT_PTS];
  logic [W-1:0]           out_q  [FFT_PTS];
  logic [W-1:0]           out_d  [FFT_PTS];
  logic                   load, out_valid_q, sof_err_q, sof_err_d;
  logic [7:0]             frame_cnt_q;

  function automatic logic [FFT_IDX_W-1:0] out_pos(input int i);
`ifdef FFT_LOADER_BITREV_EN
    return bitrev3(FFT_IDX_W'(i));
`else
    return FFT_IDX_W'(i);
`endif
  endfunction

  assign in_ready  = state_q == FILL;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign sof_err   = sof_err_q;
  assign {a0, a1, a2, a3, a4, a5, a6, a7} =
    {out_q[0], out_q[1], out_q[2], out_q[3], out_q[4], out_q[5], out_q[6], out_q[7]};

  // Sample capture, frame completion and the FILL/PEND decision; a completed frame
  // loads straight from bank_d so the sample arriving this cycle is included.
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    bank_d    = bank_q;
    out_d     = out_q;
    sof_err_d = sof_err_q;
    load      = 1'b0;
    idx       = in_sof ? '0 : wr_idx_q;
    if (state_q == FILL && in_valid) begin
      bank_d[idx] = in_data;
      wr_idx_d    = idx + 1'b1;
      sof_err_d   = sof_err_q | (in_sof && wr_idx_q != '0);
      if (idx == FFT_IDX_W'(FFT_PTS - 1)) begin
        state_d = out_hold ? PEND : FILL;
        load    = !out_hold;
      end
    end else if (state_q == PEND && !out_hold) begin
      state_d = FILL;
      load    = 1'b1;
    end
    if (load)
      for (int i = 0; i < FFT_PTS; i++) out_d[out_pos(i)] = bank_d[i];
  end

  // State, bank, output frame and status registers; reset drops any partial or pending frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      sof_err_q   <= 1'b0;
      for (int i = 0; i < FFT_PTS; i++) begin
        bank_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      out_valid_q <= load;
      frame_cnt_q <= frame_cnt_q + 8'(load);
      sof_err_q   <= sof_err_d;
      bank_q      <= bank_d;
      out_q       <= out_d;
    end
  end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: directed and scoreboarded checks of frame assembly, hold/pend, sof errors and reset
module tb_fft_input_loader;
  logic        clk = 0, rst = 0, in_valid = 0, in_sof = 0, out_hold = 0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, sof_err;
  logic [7:0]  frame_cnt;
  logic [15:0] a [8];
  logic [15:0] exp_f [8];
  int          errors = 0, checks = 0, exp_cnt = 0;

  fft_input_loader #(.N(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_hold(out_hold),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]), .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
    .out_valid(out_valid), .frame_cnt(frame_cnt), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  function automatic int omap(input int o);
    logic [2:0] b;
    b = o[2:0];
`ifdef FFT_LOADER_BITREV_EN
    return int'({b[0], b[1], b[2]});
`else
    return int'(b);
`endif
  endfunction

  task automatic send(input logic [15:0] d, input logic s);
    in_data = d; in_valid = 1; in_sof = s;
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0;
  endtask

  task automatic test_reset;
    rst = 0; #2;
    for (int o = 0; o < 8; o++) begin
      checks++; if (a[o] !== 16'd0) begin errors++; $display("FAIL reset_a%0d got=%0d exp=0", o, a[o]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL reset_sof_err got=%b exp=0", sof_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1; rst = 1;
    exp_cnt = 0;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 8; i++) begin
      exp_f[i] = 16'(i + 1);
      send(16'(i + 1), i == 0);
      if (i < 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid i=%0d got=%b exp=0", i, out_valid); end
      end
    end
    exp_cnt++;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    for (int o = 0; o < 8; o++) begin
      checks++; if (a[o] !== exp_f[omap(o)]) begin errors++; $display("FAIL basic_a%0d got=%0d exp=%0d", o, a[o], exp_f[omap(o)]); end
    end
    checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL basic_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL basic_sof_err got=%b exp=0", sof_err); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall got=%b exp=0", out_valid); end
    checks++; if (a[0] !== exp_f[omap(0)]) begin errors++; $display("FAIL basic_a0_hold got=%0d exp=%0d", a[0], exp_f[omap(0)]); end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 7; i++) send(16'(10 + i), i == 0);
    out_hold = 1;
    send(16'd17, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_k got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_k got=%b exp=0", in_ready); end
    in_valid = 1; in_data = 16'd99;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready k=%0d got=%b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid k=%0d got=%b exp=0", k, out_valid); end
    end
    out_hold = 0;
    @(posedge clk); #1;
    in_valid = 0;
    exp_cnt++;
    for (int i = 0; i < 8; i++) exp_f[i] = 16'(10 + i);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_release_valid got=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
    checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL hold_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL hold_sof_err got=%b exp=0", sof_err); end
    for (int o = 0; o < 8; o++) begin
      checks++; if (a[o] !== exp_f[omap(o)]) begin errors++; $display("FAIL hold_a%0d got=%0d exp=%0d", o, a[o], exp_f[omap(o)]); end
    end
    for (int i = 0; i < 8; i++) begin
      exp_f[i] = 16'(20 + i);
      send(16'(20 + i), 0);
    end
    exp_cnt++;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_next_valid got=%b exp=1", out_valid); end
    for (int o = 0; o < 8; o++) begin
      checks++; if (a[o] !== exp_f[omap(o)]) begin errors++; $display("FAIL hold_next_a%0d got=%0d exp=%0d", o, a[o], exp_f[omap(o)]); end
    end
  endtask

  task automatic test_sof_err;
    for (int i = 0; i < 3; i++) send(16'(50 + i), 0);
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL sof_pre got=%b exp=0", sof_err); end
    send(16'd100, 1);
    checks++; if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_set got=%b exp=1", sof_err); end
    for (int i = 1; i < 8; i++) send(16'(100 + i), 0);
    exp_cnt++;
    for (int i = 0; i < 8; i++) exp_f[i] = 16'(100 + i);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sof_valid got=%b exp=1", out_valid); end
    checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL sof_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    checks++; if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_sticky got=%b exp=1", sof_err); end
    for (int o = 0; o < 8; o++) begin
      checks++; if (a[o] !== exp_f[omap(o)]) begin errors++; $display("FAIL sof_a%0d got=%0d exp=%0d", o, a[o], exp_f[omap(o)]); end
    end
  endtask

  task automatic test_reset_mid;
    out_hold = 1;
    for (int i = 0; i < 8; i++) send(16'(30 + i), i == 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rpend_ready_before got=%b exp=0", in_ready); end
    #2; rst = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rpend_ready got=%b exp=1", in_ready); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rpend_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL rpend_sof_err got=%b exp=0", sof_err); end
    checks++; if (a[0] !== 16'd0) begin errors++; $display("FAIL rpend_a0 got=%0d exp=0", a[0]); end
    @(posedge clk); #1; rst = 1; out_hold = 0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rpend_no_stale got=%b exp=0", out_valid); end
    for (int i = 0; i < 4; i++) send(16'(40 + i), 0);
    #2; rst = 0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rfill_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rfill_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1; rst = 1;
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_f[i] = 16'(60 + i);
      send(16'(60 + i), 0);
    end
    exp_cnt++;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rafter_valid got=%b exp=1", out_valid); end
    checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rafter_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    for (int o = 0; o < 8; o++) begin
      checks++; if (a[o] !== exp_f[omap(o)]) begin errors++; $display("FAIL rafter_a%0d got=%0d exp=%0d", o, a[o], exp_f[omap(o)]); end
    end
  endtask

  task automatic test_back_to_back;
    rst = 0; @(posedge clk); #1; rst = 1;
    exp_cnt = 0;
    in_valid = 1;
    for (int c = 0; c < 2048; c++) begin
      in_data = 16'(c); in_sof = (c % 8) == 0;
      @(posedge clk); #1;
      if (c % 8 == 7) exp_cnt++;
      checks++; if (out_valid !== ((c % 8) == 7)) begin errors++; $display("FAIL b2b_valid c=%0d got=%b", c, out_valid); end
      if (c % 8 == 7) begin
        checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_frame_cnt c=%0d got=%0d exp=%0d", c, frame_cnt, exp_cnt & 255); end
      end
    end
    in_valid = 0; in_sof = 0;
    for (int i = 0; i < 8; i++) exp_f[i] = 16'(2040 + i);
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL b2b_wrap got=%0d exp=0", frame_cnt); end
    for (int o = 0; o < 8; o++) begin
      checks++; if (a[o] !== exp_f[omap(o)]) begin errors++; $display("FAIL b2b_a%0d got=%0d exp=%0d", o, a[o], exp_f[omap(o)]); end
    end
  endtask

  task automatic test_random;
    logic [15:0] cur [8];
    int m = 0;
    for (int c = 0; c < 400; c++) begin
      logic v, done;
      logic [15:0] d;
      v = $urandom_range(0, 9) >= 3;
      d = 16'(int'($urandom_range(0, 15)) - 8);
      in_valid = v; in_data = d;
      @(posedge clk); #1;
      in_valid = 0;
      done = 0;
      if (v) begin
        cur[m] = d;
        if (m == 7) begin
          done = 1; exp_f = cur; exp_cnt++;
        end
        m = (m + 1) % 8;
      end
      checks++; if (out_valid !== done) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, done); end
      for (int o = 0; o < 8; o++) begin
        checks++; if (a[o] !== exp_f[omap(o)]) begin errors++; $display("FAIL rand_a%0d c=%0d got=%0d exp=%0d", o, c, a[o], exp_f[omap(o)]); end
      end
      if (done) begin
        checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rand_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt & 255); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_sof_err;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
